// File: rtl/mtime_counter_pkg.sv
// Shared definitions for the mtime producer and the CLINT bus decode:
// address map, prescaler width default, mtime/word types and the byte-merge helper.
package mtime_counter_pkg;

   localparam logic [31:0] CLINT_MSIP_ADDR       = 32'h1100_0000;
   localparam logic [31:0] CLINT_MTIMECMP_L_ADDR = 32'h1100_4000;
   localparam logic [31:0] CLINT_MTIMECMP_H_ADDR = 32'h1100_4004;
   localparam logic [31:0] CLINT_MTIME_L_ADDR    = 32'h1100_BFF8;
   localparam logic [31:0] CLINT_MTIME_H_ADDR    = 32'h1100_BFFC;

   localparam int DIV_WIDTH_DEFAULT = 16;

   typedef logic [63:0] mtime_t;
   typedef logic [31:0] word_t;
   typedef logic [3:0]  wmask_t;

   // Replace only the enabled bytes of cur with the matching bytes of data.
   function automatic word_t merge_bytes(input word_t cur, input word_t data, input wmask_t mask);
      word_t res;
      res = cur;
      for (int b = 0; b < 4; b++) begin
         if (mask[b]) res[b*8 +: 8] = data[b*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/mtime_counter_if.sv
// Write port of the mtime block: 32-bit byte-masked writes to either half of mtime.
interface mtime_counter_if;
   import mtime_counter_pkg::*;

   logic   wr_valid;
   logic   wr_hi;
   wmask_t wr_wmask;
   word_t  wr_wdata;
   logic   wr_ready;

   modport master (output wr_valid, output wr_hi, output wr_wmask, output wr_wdata, input wr_ready);
   modport slave  (input wr_valid, input wr_hi, input wr_wmask, input wr_wdata, output wr_ready);

endinterface

// File: rtl/mtime_counter_prescaler.sv
// Clock prescaler for mtime: counts enabled cycles and flags the terminal count.
module mtime_prescaler
   import mtime_counter_pkg::*;
#(
   parameter int DIV_WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [DIV_WIDTH-1:0] div,
   input  logic                 en,
   input  logic                 clear,
   output logic                 terminal
);

   logic [DIV_WIDTH-1:0] count;
   logic [DIV_WIDTH-1:0] div_m1;

   // >= rather than == so lowering div mid-count terminates at once instead of wrapping.
   assign div_m1   = (div == '0) ? '0 : div - DIV_WIDTH'(1);
   assign terminal = (count >= div_m1);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (en) begin
         count <= terminal ? '0 : count + DIV_WIDTH'(1);
      end
   end

endmodule

// File: rtl/mtime_counter.sv
// 64-bit mtime source for the CLINT: prescaled increment, byte-masked writes, optional
// tear-free snapshot register enabled by defining MTIME_SNAPSHOT_EN.
module mtime_counter
   import mtime_counter_pkg::*;
#(
   parameter int     DIV_WIDTH   = DIV_WIDTH_DEFAULT,
   parameter mtime_t RESET_VALUE = 64'h0
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [DIV_WIDTH-1:0] div,
   input  logic                 en,
   input  logic                 snap,
   mtime_counter_if.slave       wr,
   output logic                 tick,
   output mtime_t               timer_snapshot,
   output mtime_t               timer_counter
);

   logic terminal;

   mtime_prescaler #(.DIV_WIDTH(DIV_WIDTH)) u_prescaler (
      .clk      (clk),
      .resetn   (resetn),
      .div      (div),
      .en       (en),
      .clear    (wr.wr_valid),
      .terminal (terminal)
   );

   // A write always wins over the increment; the prescaler restarts on the same edge.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         timer_counter <= RESET_VALUE;
         tick          <= 1'b0;
         wr.wr_ready   <= 1'b0;
      end else begin
         wr.wr_ready <= wr.wr_valid;
         if (wr.wr_valid) begin
            if (wr.wr_hi) begin
               timer_counter[63:32] <= merge_bytes(timer_counter[63:32], wr.wr_wdata, wr.wr_wmask);
            end else begin
               timer_counter[31:0]  <= merge_bytes(timer_counter[31:0], wr.wr_wdata, wr.wr_wmask);
            end
            tick <= 1'b0;
         end else if (en && terminal) begin
            timer_counter <= timer_counter + 64'd1;
            tick          <= 1'b1;
         end else begin
            tick <= 1'b0;
         end
      end
   end

`ifdef MTIME_SNAPSHOT_EN
   // Captures the value visible this cycle, so a coincident write or increment is not seen.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         timer_snapshot <= RESET_VALUE;
      end else if (snap) begin
         timer_snapshot <= timer_counter;
      end
   end
`else
   logic unused_snap;
   assign unused_snap    = snap;
   assign timer_snapshot = timer_counter;
`endif

endmodule

// File: tb/tb_mtime_counter.sv
// Self-checking bench for mtime_counter: directed vector table, corner sequences and
// randomized traffic against an edge-counting reference model (honours MTIME_SNAPSHOT_EN).
module tb_mtime_counter;

   logic        clk = 1'b0;
   logic        resetn;
   logic [15:0] div;
   logic        en;
   logic        snap;
   logic        tick;
   logic [63:0] timer_snapshot;
   logic [63:0] timer_counter;

   int total = 0;
   int bad   = 0;

   mtime_counter_if bus ();

   mtime_counter dut (
      .clk            (clk),
      .resetn         (resetn),
      .div            (div),
      .en             (en),
      .snap           (snap),
      .wr             (bus.slave),
      .tick           (tick),
      .timer_snapshot (timer_snapshot),
      .timer_counter  (timer_counter)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rn;
      logic [15:0] dv;
      logic        en;
      logic        v;
      logic        hi;
      logic [3:0]  mask;
      logic [31:0] wdata;
      logic        snap;
      logic [63:0] exp_cnt;
      logic        exp_tick;
      logic        exp_ready;
   } vec_t;

   // Reference model: mtime value and number of enabled edges since the last restart.
   logic [63:0] m_cnt   = 64'h0;
   logic [63:0] m_snap  = 64'h0;
   int unsigned m_phase = 0;
   logic        m_tick  = 1'b0;
   logic        m_ready = 1'b0;

   function automatic vec_t mk(input logic rn, input logic [15:0] dv, input logic e,
                               input logic v, input logic hi, input logic [3:0] mask,
                               input logic [31:0] wdata, input logic s,
                               input logic [63:0] exp_cnt, input logic exp_tick, input logic exp_ready);
      vec_t r;
      r.rn = rn; r.dv = dv; r.en = e; r.v = v; r.hi = hi; r.mask = mask;
      r.wdata = wdata; r.snap = s; r.exp_cnt = exp_cnt; r.exp_tick = exp_tick; r.exp_ready = exp_ready;
      return r;
   endfunction

   task automatic model_edge(input vec_t x);
      logic [63:0] pre;
      logic [31:0] bm;
      int unsigned period;
      pre = m_cnt;
      if (!x.rn) begin
         m_cnt = 64'h0; m_snap = 64'h0; m_phase = 0; m_tick = 1'b0; m_ready = 1'b0;
      end else begin
         m_ready = x.v;
`ifdef MTIME_SNAPSHOT_EN
         if (x.snap) m_snap = pre;
`endif
         if (x.v) begin
            bm = {{8{x.mask[3]}}, {8{x.mask[2]}}, {8{x.mask[1]}}, {8{x.mask[0]}}};
            if (x.hi) m_cnt[63:32] = (m_cnt[63:32] & ~bm) | (x.wdata & bm);
            else      m_cnt[31:0]  = (m_cnt[31:0]  & ~bm) | (x.wdata & bm);
            m_phase = 0;
            m_tick  = 1'b0;
         end else if (x.en) begin
            period  = (x.dv == 16'd0) ? 1 : int'(x.dv);
            m_phase = m_phase + 1;
            if (m_phase >= period) begin
               m_cnt   = m_cnt + 64'd1;
               m_phase = 0;
               m_tick  = 1'b1;
            end else begin
               m_tick = 1'b0;
            end
         end else begin
            m_tick = 1'b0;
         end
      end
`ifndef MTIME_SNAPSHOT_EN
      m_snap = m_cnt;
`endif
   endtask

   task automatic applyStimulus(input vec_t x);
      resetn       = x.rn;
      div          = x.dv;
      en           = x.en;
      snap         = x.snap;
      bus.wr_valid = x.v;
      bus.wr_hi    = x.hi;
      bus.wr_wmask = x.mask;
      bus.wr_wdata = x.wdata;
      @(posedge clk);
      model_edge(x);
      #1;
   endtask

   task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string name);
      checkValue({name, "_cnt"},   timer_counter,         m_cnt);
      checkValue({name, "_tick"},  {63'h0, tick},         {63'h0, m_tick});
      checkValue({name, "_ready"}, {63'h0, bus.wr_ready}, {63'h0, m_ready});
      checkValue({name, "_snap"},  timer_snapshot,        m_snap);
   endtask

   task automatic step(input string name, input vec_t x);
      applyStimulus(x);
      checkOutput(name);
   endtask

   vec_t vecs[$];

   initial begin
      // Directed table: div=4 cadence, div=0/1 every cycle, full preload and 64-bit wrap.
      vecs.push_back(mk(0, 4, 0, 0, 0, 4'h0, 32'h0, 0, 64'h0, 0, 0));
      for (int i = 1; i <= 12; i++)
         vecs.push_back(mk(1, 4, 1, 0, 0, 4'h0, 32'h0, 0, 64'(i / 4), (i % 4) == 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 4'h0, 32'h0, 0, 64'h0, 0, 0));
      for (int i = 1; i <= 5; i++)
         vecs.push_back(mk(1, 0, 1, 0, 0, 4'h0, 32'h0, 0, 64'(i), 1, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 4'h0, 32'h0, 0, 64'h0, 0, 0));
      for (int i = 1; i <= 5; i++)
         vecs.push_back(mk(1, 1, 1, 0, 0, 4'h0, 32'h0, 0, 64'(i), 1, 0));
      vecs.push_back(mk(1, 1, 0, 1, 1, 4'hF, 32'hFFFF_FFFF, 0, 64'hFFFF_FFFF_0000_0005, 0, 1));
      vecs.push_back(mk(1, 1, 0, 1, 0, 4'hF, 32'hFFFF_FFFF, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1));
      vecs.push_back(mk(1, 1, 1, 0, 0, 4'h0, 32'h0,         0, 64'h0, 1, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         checkValue($sformatf("vec%0d_cnt", i),   timer_counter,         vecs[i].exp_cnt);
         checkValue($sformatf("vec%0d_tick", i),  {63'h0, tick},         {63'h0, vecs[i].exp_tick});
         checkValue($sformatf("vec%0d_ready", i), {63'h0, bus.wr_ready}, {63'h0, vecs[i].exp_ready});
         checkOutput($sformatf("vec%0d_model", i));
      end

      // Masked write landing on a terminal edge: merge wins, no increment, prescaler restarts.
      step("mw_rst", mk(0, 4, 0, 0, 0, 4'h0, 32'h0, 0, 0, 0, 0));
      step("mw_pre", mk(1, 4, 0, 1, 0, 4'hF, 32'h1234_5678, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++) step("mw_run", mk(1, 4, 1, 0, 0, 4'h0, 32'h0, 0, 0, 0, 0));
      checkValue("mw_before", timer_counter, 64'h0000_0000_1234_5678);
      step("mw_hit", mk(1, 4, 1, 1, 0, 4'b0101, 32'hAABB_CCDD, 0, 0, 0, 0));
      checkValue("mw_merge", timer_counter, 64'h0000_0000_12BB_56DD);
      checkValue("mw_tick",  {63'h0, tick}, 64'h0);
      for (int i = 0; i < 3; i++) step("mw_after", mk(1, 4, 1, 0, 0, 4'h0, 32'h0, 0, 0, 0, 0));
      checkValue("mw_restart_hold", timer_counter, 64'h0000_0000_12BB_56DD);
      step("mw_inc", mk(1, 4, 1, 0, 0, 4'h0, 32'h0, 0, 0, 0, 0));
      checkValue("mw_restart_inc", timer_counter, 64'h0000_0000_12BB_56DE);

      // Zero-mask write: value untouched, still acknowledged, still restarts the prescaler.
      for (int i = 0; i < 2; i++) step("z_run", mk(1, 4, 1, 0, 0, 4'h0, 32'h0, 0, 0, 0, 0));
      step("z_wr", mk(1, 4, 1, 1, 1, 4'h0, 32'hDEAD_BEEF, 0, 0, 0, 0));
      checkValue("z_ready", {63'h0, bus.wr_ready}, 64'h1);
      checkValue("z_cnt",   timer_counter, 64'h0000_0000_12BB_56DE);
      for (int i = 0; i < 3; i++) step("z_after", mk(1, 4, 1, 0, 0, 4'h0, 32'h0, 0, 0, 0, 0));
      checkValue("z_hold", timer_counter, 64'h0000_0000_12BB_56DE);
      step("z_inc", mk(1, 4, 1, 0, 0, 4'h0, 32'h0, 0, 0, 0, 0));
      checkValue("z_inc_cnt", timer_counter, 64'h0000_0000_12BB_56DF);

      // div lowered mid-count, then a freeze with en low part-way into a period.
      step("dv_rst", mk(0, 100, 0, 0, 0, 4'h0, 32'h0, 0, 0, 0, 0));
      for (int i = 0; i < 50; i++) step("dv_100", mk(1, 100, 1, 0, 0, 4'h0, 32'h0, 0, 0, 0, 0));
      checkValue("dv_50_cnt", timer_counter, 64'h0);
      step("dv_10", mk(1, 10, 1, 0, 0, 4'h0, 32'h0, 0, 0, 0, 0));
      checkValue("dv_drop_cnt",  timer_counter, 64'h1);
      checkValue("dv_drop_tick", {63'h0, tick}, 64'h1);
      for (int i = 0; i < 9; i++) step("dv_10b", mk(1, 10, 1, 0, 0, 4'h0, 32'h0, 0, 0, 0, 0));
      checkValue("dv_9_cnt", timer_counter, 64'h1);
      step("dv_10c", mk(1, 10, 1, 0, 0, 4'h0, 32'h0, 0, 0, 0, 0));
      checkValue("dv_10_cnt", timer_counter, 64'h2);
      for (int i = 0; i < 4; i++) step("dv_pre", mk(1, 10, 1, 0, 0, 4'h0, 32'h0, 0, 0, 0, 0));
      for (int i = 0; i < 20; i++) step("dv_off", mk(1, 10, 0, 0, 0, 4'h0, 32'h0, 0, 0, 0, 0));
      checkValue("dv_frozen", timer_counter, 64'h2);
      for (int i = 0; i < 5; i++) step("dv_resume", mk(1, 10, 1, 0, 0, 4'h0, 32'h0, 0, 0, 0, 0));
      checkValue("dv_resume_hold", timer_counter, 64'h2);
      step("dv_resume_inc", mk(1, 10, 1, 0, 0, 4'h0, 32'h0, 0, 0, 0, 0));
      checkValue("dv_resume_cnt", timer_counter, 64'h3);

      // Snapshot taken on the same edge as a carry into the upper half.
      step("sn_rst", mk(0, 1, 0, 0, 0, 4'h0, 32'h0, 0, 0, 0, 0));
      step("sn_hi",  mk(1, 1, 0, 1, 1, 4'hF, 32'h0000_0001, 0, 0, 0, 0));
      step("sn_lo",  mk(1, 1, 0, 1, 0, 4'hF, 32'hFFFF_FFFF, 0, 0, 0, 0));
      step("sn_hit", mk(1, 1, 1, 0, 0, 4'h0, 32'h0, 1, 0, 0, 0));
      checkValue("sn_cnt", timer_counter, 64'h2_0000_0000);
`ifdef MTIME_SNAPSHOT_EN
      checkValue("sn_snap", timer_snapshot, 64'h1_FFFF_FFFF);
`else
      checkValue("sn_snap", timer_snapshot, 64'h2_0000_0000);
`endif
      step("sn_hold", mk(1, 1, 1, 0, 0, 4'h0, 32'h0, 0, 0, 0, 0));
`ifdef MTIME_SNAPSHOT_EN
      checkValue("sn_held", timer_snapshot, 64'h1_FFFF_FFFF);
`else
      checkValue("sn_track", timer_snapshot, 64'h2_0000_0001);
`endif

      // Randomized traffic, including resets mid-count and mid-write.
      for (int i = 0; i < 400; i++) begin
         vec_t r;
         r = mk(($urandom_range(0, 39) != 0), 16'($urandom_range(0, 6)), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                $urandom, ($urandom_range(0, 3) == 0), 0, 0, 0);
         step($sformatf("rnd%0d", i), r);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
